// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_ctrl
// Brief    : Clears a single-port RAM after reset, then serves one-at-a-time
//            write/read requests with a valid/ready response channel.
// Revision : 1.0
// ============================================================================
module ram_access_ctrl #(
    parameter int ADDRESS_MAX  = 16,
    parameter int ADDRESS_BITS = 4,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDRESS_BITS-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    init_done,
    output logic                    write_memory,
    output logic                    read_memory,
    output logic [ADDRESS_BITS-1:0] address,
    output logic [DATA_WIDTH-1:0]   write_memory_data,
    input  logic [DATA_WIDTH-1:0]   read_memory_data
);

    // One spare counter bit so the clear sequence can reach ADDRESS_MAX
    // without ever wrapping the address.
    localparam int                 c_CNT_W    = ADDRESS_BITS + 1;
    localparam logic [c_CNT_W-1:0] c_INIT_END = c_CNT_W'(ADDRESS_MAX);

    localparam logic [2:0] c_ST_INIT  = 3'd0;
    localparam logic [2:0] c_ST_IDLE  = 3'd1;
    localparam logic [2:0] c_ST_WRITE = 3'd2;
    localparam logic [2:0] c_ST_READ  = 3'd3;
    localparam logic [2:0] c_ST_RWAIT = 3'd4;
    localparam logic [2:0] c_ST_RESP  = 3'd5;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [c_CNT_W-1:0]      r_init_cnt;
    logic [c_CNT_W-1:0]      w_init_cnt_nxt;

    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_init_done;
    logic                    r_write_memory;
    logic                    r_read_memory;
    logic [ADDRESS_BITS-1:0] r_address;
    logic [DATA_WIDTH-1:0]   r_write_memory_data;

    logic                    w_req_ready_nxt;
    logic                    w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   w_rsp_data_nxt;
    logic                    w_init_done_nxt;
    logic                    w_write_memory_nxt;
    logic                    w_read_memory_nxt;
    logic [ADDRESS_BITS-1:0] w_address_nxt;
    logic [DATA_WIDTH-1:0]   w_write_memory_data_nxt;

    logic                    w_req_fire;
    logic                    w_rsp_fire;

    assign w_req_fire = (r_state == c_ST_IDLE) && req_valid;
    assign w_rsp_fire = r_rsp_valid && rsp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT: begin
                if (r_init_cnt == c_INIT_END) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                if (w_req_fire) begin
                    w_state_nxt = req_write ? c_ST_WRITE : c_ST_READ;
                end
            end
            c_ST_WRITE: w_state_nxt = c_ST_IDLE;
            c_ST_READ:  w_state_nxt = c_ST_RWAIT;
            c_ST_RWAIT: w_state_nxt = c_ST_RESP;
            c_ST_RESP: begin
                if (w_rsp_fire) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default:    w_state_nxt = c_ST_INIT;
        endcase
    end

    // Output logic: every output is a flop loaded with the value for the state
    // being entered, so reset clears them and the strobes stay glitch-free.
    always_comb begin
        w_init_cnt_nxt          = r_init_cnt;
        w_req_ready_nxt         = (w_state_nxt == c_ST_IDLE);
        w_rsp_valid_nxt         = 1'b0;
        w_rsp_data_nxt          = r_rsp_data;
        w_init_done_nxt         = r_init_done;
        w_write_memory_nxt      = 1'b0;
        w_read_memory_nxt       = 1'b0;
        w_address_nxt           = r_address;
        w_write_memory_data_nxt = r_write_memory_data;
        case (r_state)
            c_ST_INIT: begin
                if (r_init_cnt == c_INIT_END) begin
                    w_init_done_nxt = 1'b1;
                end else begin
                    w_write_memory_nxt      = 1'b1;
                    w_address_nxt           = r_init_cnt[ADDRESS_BITS-1:0];
                    w_write_memory_data_nxt = '0;
                    w_init_cnt_nxt          = r_init_cnt + 1'b1;
                end
            end
            c_ST_IDLE: begin
                if (w_req_fire) begin
                    w_address_nxt = req_addr;
                    if (req_write) begin
                        w_write_memory_nxt      = 1'b1;
                        w_write_memory_data_nxt = req_wdata;
                    end else begin
                        w_read_memory_nxt = 1'b1;
                    end
                end
            end
            c_ST_RWAIT: begin
                w_rsp_data_nxt = read_memory_data;
            end
            c_ST_RESP: begin
                // First RESP cycle raises rsp_valid; it then holds until taken.
                w_rsp_valid_nxt = !w_rsp_fire;
            end
            default: begin
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt          <= '0;
            r_req_ready         <= 1'b0;
            r_rsp_valid         <= 1'b0;
            r_rsp_data          <= '0;
            r_init_done         <= 1'b0;
            r_write_memory      <= 1'b0;
            r_read_memory       <= 1'b0;
            r_address           <= '0;
            r_write_memory_data <= '0;
        end else begin
            r_init_cnt          <= w_init_cnt_nxt;
            r_req_ready         <= w_req_ready_nxt;
            r_rsp_valid         <= w_rsp_valid_nxt;
            r_rsp_data          <= w_rsp_data_nxt;
            r_init_done         <= w_init_done_nxt;
            r_write_memory      <= w_write_memory_nxt;
            r_read_memory       <= w_read_memory_nxt;
            r_address           <= w_address_nxt;
            r_write_memory_data <= w_write_memory_data_nxt;
        end
    end

    assign req_ready         = r_req_ready;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_data          = r_rsp_data;
    assign init_done         = r_init_done;
    assign write_memory      = r_write_memory;
    assign read_memory       = r_read_memory;
    assign address           = r_address;
    assign write_memory_data = r_write_memory_data;

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(write_memory && read_memory));

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_ctrl
// Brief    : Self-checking bench for ram_access_ctrl with a behavioural RAM
//            and a reference memory image.
// Revision : 1.0
// ============================================================================
module tb_ram_access_ctrl;

    localparam int c_AMAX = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        init_done;
    logic        write_memory;
    logic        read_memory;
    logic [3:0]  address;
    logic [15:0] write_memory_data;
    logic [15:0] read_memory_data;

    int n_asserts  = 0;
    int n_failures = 0;

    logic [15:0] ram     [16];
    logic [15:0] ref_mem [16];

    ram_access_ctrl #(
        .ADDRESS_MAX (16),
        .ADDRESS_BITS(4),
        .DATA_WIDTH  (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .init_done        (init_done),
        .write_memory     (write_memory),
        .read_memory      (read_memory),
        .address          (address),
        .write_memory_data(write_memory_data),
        .read_memory_data (read_memory_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the strobe edge.
    always @(posedge clk) begin
        if (write_memory) ram[address] <= write_memory_data;
        if (read_memory)  read_memory_data <= ram[address];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) check_eq("strobe_excl", 32'(write_memory & read_memory), 0);
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_timeout", 32'(n < 50), 1);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_data",  32'(rsp_data), 0);
        check_eq("rst_init_done", 32'(init_done), 0);
        check_eq("rst_wr",        32'(write_memory), 0);
        check_eq("rst_rd",        32'(read_memory), 0);
        check_eq("rst_addr",      32'(address), 0);
        check_eq("rst_wdata",     32'(write_memory_data), 0);
    endtask

    // Called at the negedge where rst_n was released.
    task automatic run_init_check();
        for (int i = 0; i < c_AMAX; i++) begin
            @(negedge clk);
            check_eq("init_wr",        32'(write_memory), 1);
            check_eq("init_rd",        32'(read_memory), 0);
            check_eq("init_addr",      32'(address), 32'(i));
            check_eq("init_data",      32'(write_memory_data), 0);
            check_eq("init_done_early", 32'(init_done), 0);
            check_eq("init_ready",     32'(req_ready), 0);
        end
        @(negedge clk);
        check_eq("init_end_wr",   32'(write_memory), 0);
        check_eq("init_done",     32'(init_done), 1);
        check_eq("init_end_rdy",  32'(req_ready), 1);
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
    endtask

    // Leaves req_valid high; the caller issues the next request or clears it.
    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        wait_ready();
        @(negedge clk);
        ref_mem[a] = d;
        check_eq("wr_strobe",   32'(write_memory), 1);
        check_eq("wr_no_rd",    32'(read_memory), 0);
        check_eq("wr_addr",     32'(address), 32'(a));
        check_eq("wr_data",     32'(write_memory_data), 32'(d));
        check_eq("wr_busy",     32'(req_ready), 0);
        check_eq("init_sticky", 32'(init_done), 1);
        req_write = 1'b0;
        req_addr  = 4'($urandom);
        req_wdata = 16'($urandom);
    endtask

    task automatic do_read(input logic [3:0] a, input int hold);
        logic [15:0] exp_d;
        int lat;
        exp_d     = ref_mem[a];
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        req_wdata = 16'($urandom);
        rsp_ready = 1'b0;
        wait_ready();
        @(negedge clk);
        check_eq("rd_strobe", 32'(read_memory), 1);
        check_eq("rd_no_wr",  32'(write_memory), 0);
        check_eq("rd_addr",   32'(address), 32'(a));
        req_write = 1'($urandom);
        req_addr  = 4'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            check_eq("rd_busy", 32'(req_ready), 0);
        end
        check_eq("rd_latency", 32'(lat), 3);
        check_eq("rd_data",    32'(rsp_data), 32'(exp_d));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid), 1);
            check_eq("hold_data",  32'(rsp_data), 32'(exp_d));
            check_eq("hold_busy",  32'(req_ready), 0);
            check_eq("hold_quiet", 32'(write_memory | read_memory), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("rsp_done_valid", 32'(rsp_valid), 0);
        check_eq("rsp_done_idle",  32'(req_ready), 1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  a;
        logic [15:0] d;
        for (int i = 0; i < 16; i++) ram[i] = 16'($urandom) | 16'h0001;
        read_memory_data = 16'h0000;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 16'h0000;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        run_init_check();

        // Cleared location reads back zero
        do_read(4'h7, 0);
        req_valid = 1'b0;
        @(negedge clk);

        do_write(4'hF, 16'hFFFF);
        do_write(4'hE, 16'hFF00);
        do_read(4'hF, 0);
        do_read(4'hE, 0);
        req_valid = 1'b0;

        // Consumer stalls for five cycles
        do_read(4'hF, 5);
        req_valid = 1'b0;

        // Request held high continuously across alternating ops
        do_write(4'h3, 16'h1234);
        do_read(4'h3, 0);
        do_write(4'h3, 16'hABCD);
        do_read(4'h3, 1);
        req_valid = 1'b0;

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                @(negedge clk);
            end
            a = 4'($urandom);
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, d);
            else                           do_read(a, $urandom_range(0, 3));
        end
        req_valid = 1'b0;
        @(negedge clk);

        // Reset while waiting for read data
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'hF;
        wait_ready();
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_hold_valid", 32'(rsp_valid), 0);
            check_eq("rst_hold_ready", 32'(req_ready), 0);
            check_eq("rst_hold_wr",    32'(write_memory), 0);
        end
        rst_n = 1'b1;
        run_init_check();
        do_read(4'hF, 1);
        req_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
